gcd_dispatcher: RTL and testbench
=================================

GCD_DISPATCHER -- requirements
Module: gcd_dispatcher

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning result-FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-003 The block SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port in_valid  in  1  operand pair offered.
REQ-005 The block SHALL have port in_ready  out  1  operand pair accepted when in_valid and in_ready are both high at a clk edge.
REQ-006 The block SHALL have ports in_a, in_b  in  32  operands.
REQ-007 The block SHALL have port out_valid  out  1  result available at FIFO head.
REQ-008 The block SHALL have port out_ready  in  1  consumer pops the head when out_valid and out_ready are both high.
REQ-009 The block SHALL have port out_r  out  32  FIFO head result.
REQ-010 The block SHALL have ports core_start  out  1,  core_a  out  32,  core_b  out  32  drive the GCD core.
REQ-011 The block SHALL have ports core_ready  in  1,  core_done  in  1,  core_r  in  32  from the GCD core.
REQ-012 The block SHALL have port ops_done  out  16  count of results pushed, wraps modulo 2^16.

Function
REQ-013 The FSM SHALL have exactly three states: S_IDLE, S_START, S_WAIT.
REQ-014 in_ready SHALL be combinational and high only when all hold: state S_IDLE, core_ready high, FIFO not full.
REQ-015 On an S_IDLE accept with in_a != 0 and in_b != 0, the block SHALL register in_a into core_a and in_b into core_b, then go to S_START.
REQ-016 On an S_IDLE accept with in_a == 0 or in_b == 0, the block SHALL push (in_a | in_b) into the FIFO on that edge, never assert core_start, and stay in S_IDLE.
REQ-017 In S_START, core_start SHALL be high for exactly one cycle, then the FSM SHALL go to S_WAIT.
REQ-018 core_start SHALL be low in every state other than S_START.
REQ-019 In S_WAIT, when core_done is high, the block SHALL push core_r into the FIFO and go to S_IDLE on the same edge.
REQ-020 core_a and core_b SHALL hold their values from the accept until the next accept.
REQ-021 At most one operation SHALL be outstanding at any time.
REQ-022 Because the accept requires FIFO not full, a push SHALL never occur while the FIFO is full.
REQ-023 core_done seen in S_IDLE or S_START SHALL be ignored.
REQ-024 The FIFO SHALL be first-in first-out.
REQ-025 out_valid SHALL equal FIFO not empty.
REQ-026 out_r SHALL be the head entry, registered.
REQ-027 A push and a pop in the same cycle SHALL leave the occupancy unchanged, including when the FIFO is empty or full.
REQ-028 Minimum latency for a nonzero pair SHALL be: accept at edge T, core_start high in cycle T+1, push on the core_done edge, out_valid high in the following cycle.
REQ-029 Minimum latency for a zero-operand pair SHALL be: out_valid high in the cycle after the accept edge.
REQ-030 ops_done SHALL increment by 1 on every push.

Reset
REQ-031 While rst_n is low at a clk edge, the block SHALL set: state S_IDLE; FIFO empty (out_valid 0); out_r 0; core_start 0; core_a 0; core_b 0; ops_done 0.
REQ-032 A reset in S_START or S_WAIT SHALL abandon the operation with no push; the core shares rst_n, and a stale core_done after reset SHALL be ignored per REQ-023.

Structure
REQ-033 Package gcd_pkg SHALL hold the data width constant (32), the FSM state encoding, and the ops_done width (16).
REQ-034 The FIFO SHALL be a separate sub-module gcd_result_fifo (parameter DEPTH; push, pop, full, empty, head data).
REQ-035 The dispatcher SHALL instantiate gcd_result_fifo and SHALL NOT instantiate the GCD core; the core is connected at the top level.

Verification
REQ-036 Nonzero pair: (48,18) with a core model -> core_start exactly 1 cycle, core_a=48, core_b=18; out_r=6, ops_done=1.
REQ-037 Zero operands: (0,35) -> out_r=35, core_start never high; (0,0) -> out_r=0; ops_done=2 after both.
REQ-038 Back-pressure: out_ready=0 with pairs (12,8),(9,6),(7,5),(100,75),(21,14) offered -> 4 results buffered and in_ready low; then out_ready=1 -> 4,3,1,25,7 in order.
REQ-039 Pipeline: pair (1071,462) accepted while the FIFO holds 3 entries, with simultaneous pop and core_done push -> occupancy stays 3; out_r later shows 21.
REQ-040 Reset in S_WAIT during (270,192) -> out_valid=0, core_start=0, ops_done=0; a core_done pulse 2 cycles later produces no push.
REQ-041 Counter wrap: preset by 65536 zero-operand pushes -> ops_done returns to 0.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared constants and types for the GCD dispatcher slice.
//   DATA_W  - operand/result width
//   OPS_W   - width of the completed-operation counter
//   state_t - dispatcher FSM state encoding
package gcd_pkg;

  localparam int DATA_W = 32;
  localparam int OPS_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_dispatcher_if.sv
// gcd_dispatcher_if: bundles the operand stream, result stream and GCD core
// handshake of the dispatcher.
//   in_valid/in_ready/in_a/in_b          - operand pair stream into the block
//   out_valid/out_ready/out_r            - result stream out of the FIFO head
//   core_start/core_a/core_b             - command to the external GCD core
//   core_ready/core_done/core_r          - status and result from the core
//   ops_done                             - count of results pushed
// slave modport is the dispatcher side; master is the environment side.
interface gcd_dispatcher_if;
  import gcd_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_r;
  logic              core_start;
  logic [DATA_W-1:0] core_a;
  logic [DATA_W-1:0] core_b;
  logic              core_ready;
  logic              core_done;
  logic [DATA_W-1:0] core_r;
  logic [OPS_W-1:0]  ops_done;

  modport slave (
    input  in_valid, in_a, in_b, out_ready, core_ready, core_done, core_r,
    output in_ready, out_valid, out_r, core_start, core_a, core_b, ops_done
  );

  modport master (
    output in_valid, in_a, in_b, out_ready, core_ready, core_done, core_r,
    input  in_ready, out_valid, out_r, core_start, core_a, core_b, ops_done
  );

endinterface

// File: rtl/gcd_result_fifo.sv
// gcd_result_fifo: result FIFO with a registered head output.
//   clk, rst_n (sync, active-low)
//   push, push_data - write one entry
//   pop             - remove the head entry (ignored when empty)
//   full, empty     - occupancy flags
//   head            - registered copy of the current head entry
// DEPTH must be a power of two (2..16) so the pointers wrap naturally.
module gcd_result_fifo
  import gcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_ONE;
      end else if (do_pop && !do_push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // head tracks what the head entry will be after this edge: the next stored
  // entry on a pop, or the incoming data when it lands in an empty slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
    end else if (do_pop) begin
      if (count > CNT_ONE) begin
        head <= mem[rd_ptr + PTR_ONE];
      end else if (do_push) begin
        head <= push_data;
      end
    end else if (empty && do_push) begin
      head <= push_data;
    end
  end

endmodule

// File: rtl/gcd_dispatcher.sv
// gcd_dispatcher: accepts operand pairs, hands nonzero pairs to an external
// GCD core one at a time, short-circuits pairs containing a zero operand, and
// queues every result in gcd_result_fifo.
//   clk, rst_n (sync, active-low)
//   bus (gcd_dispatcher_if.slave) - operand stream, result stream, core
//                                   command/status and the ops_done counter
module gcd_dispatcher
  import gcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gcd_dispatcher_if.slave      bus
);

  state_t            state;
  logic              core_start_q;
  logic [DATA_W-1:0] core_a_q;
  logic [DATA_W-1:0] core_b_q;
  logic [OPS_W-1:0]  ops_done_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              accept;
  logic              operand_zero;

  assign bus.in_ready  = (state == S_IDLE) && bus.core_ready && !fifo_full;
  assign accept        = bus.in_valid && bus.in_ready;
  assign operand_zero  = (bus.in_a == '0) || (bus.in_b == '0);
  assign fifo_pop      = bus.out_ready && !fifo_empty;

  assign bus.out_valid  = !fifo_empty;
  assign bus.core_start = core_start_q;
  assign bus.core_a     = core_a_q;
  assign bus.core_b     = core_b_q;
  assign bus.ops_done   = ops_done_q;

  // A zero operand makes the GCD the other operand, so a | b is the answer
  // and the core is never involved. Accept is only possible in S_IDLE, so the
  // two push sources can never collide.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (accept && operand_zero) begin
      push      = 1'b1;
      push_data = bus.in_a | bus.in_b;
    end else if (state == S_WAIT && bus.core_done) begin
      push      = 1'b1;
      push_data = bus.core_r;
    end
  end

  // core_done outside S_WAIT (including a stale pulse after reset) is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      core_start_q <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && !operand_zero) begin
            core_a_q     <= bus.in_a;
            core_b_q     <= bus.in_b;
            core_start_q <= 1'b1;
            state        <= S_START;
          end
        end
        S_START: begin
          core_start_q <= 1'b0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.core_done) begin
            state <= S_IDLE;
          end
        end
        default: begin
          core_start_q <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ops_done_q <= '0;
    end else if (push) begin
      ops_done_q <= ops_done_q + OPS_W'(1);
    end
  end

  gcd_result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (bus.out_r)
  );

endmodule

// File: tb/tb_gcd_dispatcher.sv
// tb_gcd_dispatcher: self-checking bench for gcd_dispatcher.
// A behavioural model (result queue, outstanding-operation flag, push counter)
// is compared with the DUT on every falling edge; directed scenarios pin the
// model with hand-computed values; a GCD core model answers core_start.
module tb_gcd_dispatcher;

  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  gcd_dispatcher_if bus ();

  gcd_dispatcher #(
    .DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // core model controls
  logic        manualCore  = 1'b0;
  logic        manDone     = 1'b0;
  logic [31:0] manR        = '0;
  logic        autoDone    = 1'b0;
  logic [31:0] autoR       = '0;
  logic        autoReady   = 1'b1;
  logic        readyJitter = 1'b0;
  int          coreLatMin  = 1;
  int          coreLatMax  = 4;

  assign bus.core_done  = manualCore ? manDone : autoDone;
  assign bus.core_r     = manualCore ? manR    : autoR;
  assign bus.core_ready = manualCore ? 1'b1    : autoReady;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] refGcd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // binary GCD, deliberately a different algorithm from refGcd
  function automatic logic [31:0] binGcd(input logic [31:0] a, input logic [31:0] b);
    int k = 0;
    logic [31:0] t;
    if (a == 0) return b;
    if (b == 0) return a;
    while (((a | b) & 32'd1) == 0) begin
      a = a >> 1;
      b = b >> 1;
      k++;
    end
    while ((a & 32'd1) == 0) a = a >> 1;
    while (b != 0) begin
      while ((b & 32'd1) == 0) b = b >> 1;
      if (a > b) begin
        t = a;
        a = b;
        b = t;
      end
      b = b - a;
    end
    return a << k;
  endfunction

  // GCD core model: latches operands when it sees core_start, answers with a
  // one-cycle core_done after a random latency.
  always begin : core_model
    logic        busy;
    int          cnt;
    logic [31:0] opA;
    logic [31:0] opB;
    busy = 1'b0;
    cnt  = 0;
    opA  = '0;
    opB  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy      = 1'b0;
        autoDone  = 1'b0;
        autoReady = 1'b1;
      end else begin
        if (autoDone) begin
          autoDone = 1'b0;
          busy     = 1'b0;
        end
        if (busy) begin
          if (cnt <= 1) begin
            autoDone = 1'b1;
            autoR    = binGcd(opA, opB);
          end else begin
            cnt--;
          end
        end else if (bus.core_start) begin
          busy = 1'b1;
          opA  = bus.core_a;
          opB  = bus.core_b;
          cnt  = $urandom_range(coreLatMax, coreLatMin);
        end
        autoReady = !busy && (!readyJitter || $urandom_range(0, 7) != 0);
      end
    end
  end

  // behavioural reference model
  logic [31:0] expQ[$];
  logic        pending   = 1'b0;
  logic        expStart  = 1'b0;
  logic [31:0] expA      = '0;
  logic [31:0] expB      = '0;
  int          pushCount = 0;
  logic        modelLive = 1'b0;

  always @(posedge clk) begin : ref_model
    logic        inRdy;
    logic        doPush;
    logic [31:0] pushVal;
    logic        newStart;
    if (!rst_n) begin
      expQ.delete();
      pending   = 1'b0;
      expStart  = 1'b0;
      expA      = '0;
      expB      = '0;
      pushCount = 0;
      modelLive = 1'b1;
    end else if (modelLive) begin
      inRdy    = !pending && bus.core_ready && (expQ.size() < DEPTH);
      doPush   = 1'b0;
      pushVal  = '0;
      newStart = 1'b0;
      if (pending) begin
        if (!expStart && bus.core_done) begin
          doPush  = 1'b1;
          pushVal = refGcd(expA, expB);
          pending = 1'b0;
        end
      end else if (bus.in_valid && inRdy) begin
        if (bus.in_a == 0 || bus.in_b == 0) begin
          doPush  = 1'b1;
          pushVal = bus.in_a | bus.in_b;
        end else begin
          expA     = bus.in_a;
          expB     = bus.in_b;
          pending  = 1'b1;
          newStart = 1'b1;
        end
      end
      if (bus.out_ready && expQ.size() > 0) void'(expQ.pop_front());
      if (doPush) begin
        expQ.push_back(pushVal);
        pushCount = (pushCount + 1) % 65536;
      end
      expStart = newStart;
    end
  end

  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("in_ready", {31'd0, bus.in_ready},
                  {31'd0, !pending && bus.core_ready && (expQ.size() < DEPTH)});
      checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, expQ.size() > 0});
      if (expQ.size() > 0) checkOutput("out_r", bus.out_r, expQ[0]);
      checkOutput("core_start", {31'd0, bus.core_start}, {31'd0, expStart});
      checkOutput("core_a", bus.core_a, expA);
      checkOutput("core_b", bus.core_b, expB);
      checkOutput("ops_done", {16'd0, bus.ops_done}, pushCount[31:0]);
    end
  end

  task automatic resetDut(input int n);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input int budget, output logic accepted);
    int n = 0;
    accepted = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    while (!accepted && n < budget) begin
      @(negedge clk);
      accepted = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] b);
    logic acc;
    applyStimulus(a, b, 200, acc);
    checkOutput("accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic popExpect(input string name, input logic [31:0] expected);
    int n = 0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    if (bus.out_valid) checkOutput(name, bus.out_r, expected);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] randOperand(input int g);
    if ($urandom_range(0, 9) == 0) return 32'd0;
    if ($urandom_range(0, 9) == 0) return $urandom;
    return 32'(g * $urandom_range(1, 300));
  endfunction

  initial begin
    logic acc;
    int   g;
    int   accepted;
    int   n;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    resetDut(3);

    @(negedge clk);
    checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("reset_out_r", bus.out_r, 32'd0);
    checkOutput("reset_ops_done", {16'd0, bus.ops_done}, 32'd0);

    // nonzero pair through the core
    offer(32'd48, 32'd18);
    @(negedge clk);
    checkOutput("start_pulse", {31'd0, bus.core_start}, 32'd1);
    checkOutput("start_a", bus.core_a, 32'd48);
    checkOutput("start_b", bus.core_b, 32'd18);
    @(negedge clk);
    checkOutput("start_drop", {31'd0, bus.core_start}, 32'd0);
    popExpect("gcd_48_18", 32'd6);
    checkOutput("ops_after_48_18", {16'd0, bus.ops_done}, 32'd1);

    // zero-operand short circuit
    resetDut(2);
    offer(32'd0, 32'd35);
    offer(32'd0, 32'd0);
    popExpect("zero_0_35", 32'd35);
    popExpect("zero_0_0", 32'd0);
    @(negedge clk);
    checkOutput("ops_after_zero", {16'd0, bus.ops_done}, 32'd2);

    // back-pressure: four results fill the FIFO, the fifth pair waits
    resetDut(2);
    offer(32'd12, 32'd8);
    offer(32'd9, 32'd6);
    offer(32'd7, 32'd5);
    offer(32'd100, 32'd75);
    fork
      begin
        applyStimulus(32'd21, 32'd14, 400, acc);
        checkOutput("bp_fifth_accept", {31'd0, acc}, 32'd1);
      end
      begin
        repeat (20) @(negedge clk);
        checkOutput("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("bp_buffered", {16'd0, bus.ops_done}, 32'd4);
        popExpect("bp_r0", 32'd4);
        popExpect("bp_r1", 32'd3);
        popExpect("bp_r2", 32'd1);
        popExpect("bp_r3", 32'd25);
        popExpect("bp_r4", 32'd7);
      end
    join

    // simultaneous pop and core_done push with three entries queued
    resetDut(2);
    manualCore = 1'b1;
    offer(32'd0, 32'd1);
    offer(32'd0, 32'd2);
    offer(32'd0, 32'd3);
    offer(32'd1071, 32'd462);
    @(posedge clk);
    #1;
    manDone       = 1'b1;
    manR          = 32'd21;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    manDone       = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("pipe_ops", {16'd0, bus.ops_done}, 32'd4);
    checkOutput("pipe_head", bus.out_r, 32'd2);
    popExpect("pipe_r0", 32'd2);
    popExpect("pipe_r1", 32'd3);
    popExpect("pipe_r2", 32'd21);
    @(negedge clk);
    checkOutput("pipe_empty", {31'd0, bus.out_valid}, 32'd0);
    manualCore = 1'b0;

    // reset while waiting on the core, then a stale core_done
    resetDut(2);
    coreLatMin = 10;
    coreLatMax = 10;
    offer(32'd270, 32'd192);
    repeat (3) @(posedge clk);
    resetDut(2);
    @(negedge clk);
    checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("rst_core_start", {31'd0, bus.core_start}, 32'd0);
    checkOutput("rst_ops_done", {16'd0, bus.ops_done}, 32'd0);
    manualCore = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    manDone = 1'b1;
    manR    = 32'd6;
    @(posedge clk);
    #1 manDone = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("stale_out_valid", {31'd0, bus.out_valid}, 32'd0);
    checkOutput("stale_ops_done", {16'd0, bus.ops_done}, 32'd0);
    manualCore = 1'b0;
    coreLatMin = 1;
    coreLatMax = 4;

    // randomized traffic against the model
    readyJitter = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      g             = $urandom_range(1, 40);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_a      = randOperand(g);
      bus.in_b      = randOperand(g);
      bus.out_ready = (i % 150 < 60) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    readyJitter   = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_empty", {31'd0, bus.out_valid}, 32'd0);

    // counter wrap after 65536 zero-operand pushes
    resetDut(2);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b1;
    bus.in_a      = '0;
    bus.in_b      = $urandom;
    bus.out_ready = 1'b1;
    accepted      = 0;
    n             = 0;
    while (accepted < 65536 && n < 70000) begin
      @(negedge clk);
      if (bus.in_ready) accepted++;
      @(posedge clk);
      #1;
      bus.in_b = $urandom;
      n++;
    end
    bus.in_valid = 1'b0;
    if (accepted < 65536) begin
      total++;
      bad++;
      $display("[TB] FAIL wrap_accepts: got %0d want 65536", accepted);
    end
    @(negedge clk);
    checkOutput("wrap_ops_done", {16'd0, bus.ops_done}, 32'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #950000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
